// File: rtl/bounce_if.sv
// Command/response bundle between a bounce generator and whatever drives it.
interface bounce_if;
    logic cmd_valid;
    logic cmd_level;
    logic cmd_ready;
    logic b;
    logic busy;
    logic done;

    modport master (output cmd_valid, cmd_level, input cmd_ready, b, busy, done);
    modport slave  (input cmd_valid, cmd_level, output cmd_ready, b, busy, done);
endinterface

// File: rtl/bounce_gen.sv
// Mechanical push-button emulator: on a level change it produces a pseudo-random
// burst of bounce toggles, then holds the new level for a settle period.
module bounce_gen #(
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          PAIR_W        = 3,
    parameter int          GAP_W         = 16,
    parameter int          SETTLE_CYCLES = 5000000
) (
    input  logic     clk,
    input  logic     rst,
    bounce_if.slave  bus
);
    localparam logic [15:0]     LFSR_INIT   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [22:0]     SETTLE_LOAD = 23'(SETTLE_CYCLES);
    localparam logic [22:0]     SETTLE_ONE  = 23'd1;
    localparam logic [PAIR_W:0] TOG_ONE     = (PAIR_W+1)'(1);
    localparam logic [GAP_W:0]  GAP_ONE     = (GAP_W+1)'(1);

    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              b_q, b_d;
    logic              done_q, done_d;
    logic [PAIR_W:0]   toggles_q, toggles_d;
    logic [GAP_W:0]    gap_q, gap_d;
    logic [22:0]       settle_q, settle_d;

    logic [PAIR_W:0]   pairs_x2;
    logic [GAP_W:0]    gap_load;

    // Even toggle count guarantees the burst ends on the requested level.
    assign pairs_x2 = {lfsr_q[PAIR_W-1:0], 1'b0};
    assign gap_load = {1'b0, lfsr_q[GAP_W-1:0]} + GAP_ONE;

    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        done_d    = 1'b0;
        toggles_d = toggles_q;
        gap_d     = gap_q;
        settle_d  = settle_q;
        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_level == b_q) begin
                        done_d = 1'b1;
                    end else begin
                        b_d       = bus.cmd_level;
                        toggles_d = pairs_x2;
                        gap_d     = gap_load;
                        if (pairs_x2 != '0) begin
                            state_d = BOUNCE;
                        end else begin
                            state_d  = SETTLE;
                            settle_d = SETTLE_LOAD;
                        end
                    end
                end
            end
            BOUNCE: begin
                if (gap_q == GAP_ONE) begin
                    b_d       = ~b_q;
                    toggles_d = toggles_q - TOG_ONE;
                    gap_d     = gap_load;
                    if (toggles_q == TOG_ONE) begin
                        state_d  = SETTLE;
                        settle_d = SETTLE_LOAD;
                    end
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_ONE) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q - SETTLE_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_INIT;
            b_q       <= 1'b0;
            done_q    <= 1'b0;
            toggles_q <= '0;
            gap_q     <= '0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            b_q       <= b_d;
            done_q    <= done_d;
            toggles_q <= toggles_d;
            gap_q     <= gap_d;
            settle_q  <= settle_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.b         = b_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen: no-op, bounce bursts against an LFSR model,
// zero-bounce seed, streamed commands and mid-sequence reset.
module tb_bounce_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_bad    = 0;

    bounce_if bus();
    bounce_if bus2();

    bounce_gen #(.SEED(16'hACE1), .PAIR_W(2), .GAP_W(2), .SETTLE_CYCLES(4))
        dut (.clk(clk), .rst(rst), .bus(bus));

    // Low bits 00 at the first accept after reset: no bounce at all.
    bounce_gen #(.SEED(16'h0004), .PAIR_W(2), .GAP_W(2), .SETTLE_CYCLES(4))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    // Reference LFSR for the main instance, advancing every clock.
    logic [15:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic run_cmd(input logic lvl, input string tag);
        logic [15:0] snap;
        logic        prev_b;
        int          toggles, gap, cyc;
        @(negedge clk);
        check_eq({tag, "_ready"}, bus.cmd_ready, 1'b1);
        snap          = lfsr_m;
        prev_b        = bus.b;
        bus.cmd_valid = 1'b1;
        bus.cmd_level = lvl;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (lvl == prev_b) begin
            check_eq({tag, "_noop_done"}, bus.done, 1'b1);
            check_eq({tag, "_noop_b"}, bus.b, prev_b);
            check_eq({tag, "_noop_busy"}, bus.busy, 1'b0);
        end else begin
            check_eq({tag, "_first_edge"}, bus.b, lvl);
            check_eq({tag, "_busy"}, bus.busy, 1'b1);
            toggles = 2 * int'(snap[1:0]);
            gap     = 1 + int'(snap[1:0]);
            cyc     = 0;
            while (toggles > 0) begin
                snap   = lfsr_m;
                prev_b = bus.b;
                @(posedge clk); #1;
                cyc++;
                if (bus.b !== prev_b) begin
                    check_eq({tag, "_gap"}, cyc, gap);
                    toggles--;
                    gap = 1 + int'(snap[1:0]);
                    cyc = 0;
                end else if (cyc > gap) begin
                    check_eq({tag, "_gap_timeout"}, cyc, gap);
                    break;
                end
            end
            cyc = 0;
            while (bus.done !== 1'b1 && cyc < 12) begin
                @(posedge clk); #1;
                cyc++;
            end
            check_eq({tag, "_settle"}, cyc, 4);
            check_eq({tag, "_final_b"}, bus.b, lvl);
            check_eq({tag, "_idle_busy"}, bus.busy, 1'b0);
        end
        @(posedge clk); #1;
        check_eq({tag, "_done_drop"}, bus.done, 1'b0);
    endtask

    initial begin
        int   cyc, accepts, dones;
        logic lvl, acc_lvl;

        bus.cmd_valid  = 1'b0;
        bus.cmd_level  = 1'b0;
        bus2.cmd_valid = 1'b0;
        bus2.cmd_level = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_b", bus.b, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero-bounce seed, accepted on the first edge with reset low.
        @(negedge clk);
        bus2.cmd_valid = 1'b1;
        bus2.cmd_level = 1'b1;
        @(posedge clk); #1;
        bus2.cmd_valid = 1'b0;
        check_eq("seed0_b", bus2.b, 1'b1);
        check_eq("seed0_busy", bus2.busy, 1'b1);
        cyc = 0;
        while (bus2.done !== 1'b1 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
            check_eq("seed0_hold", bus2.b, 1'b1);
        end
        check_eq("seed0_settle", cyc, 4);

        run_cmd(1'b0, "noop0");
        run_cmd(1'b1, "rise_a");
        run_cmd(1'b1, "noop1");
        run_cmd(1'b0, "fall_a");
        run_cmd(1'b1, "rise_b");
        run_cmd(1'b0, "fall_b");

        // cmd_valid held high with alternating levels.
        lvl           = ~bus.b;
        acc_lvl       = lvl;
        accepts       = 0;
        dones         = 0;
        cyc           = 0;
        bus.cmd_level = lvl;
        bus.cmd_valid = 1'b1;
        while (dones < 4 && cyc < 400) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                accepts++;
                acc_lvl = bus.cmd_level;
            end
            @(posedge clk); #1;
            cyc++;
            if (bus.done) begin
                dones++;
                check_eq("stream_level", bus.b, acc_lvl);
                lvl           = ~lvl;
                bus.cmd_level = lvl;
                if (dones == 4) bus.cmd_valid = 1'b0;
            end
        end
        check_eq("stream_dones", dones, 4);
        check_eq("stream_accepts", accepts, 4);

        // Abort an active sequence with an asynchronous reset pulse.
        run_cmd(1'b0, "pre_abort");
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_level = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check_eq("abort_pre_busy", bus.busy, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("abort_b", bus.b, 1'b0);
        check_eq("abort_busy", bus.busy, 1'b0);
        check_eq("abort_done", bus.done, 1'b0);
        check_eq("abort_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        run_cmd(1'b1, "post_rst");
        run_cmd(1'b0, "post_rst_fall");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 Parameter SEED, default 16'hACE1, LFSR reset value; a value of 0 SHALL be replaced by 16'h0001.
REQ-002 Parameter PAIR_W, default 3, width of the bounce-pair count (1..8).
REQ-003 Parameter GAP_W, default 16, width of the inter-toggle gap field (1..16).
REQ-004 Parameter SETTLE_CYCLES, default 5000000, stable-hold cycles after the last toggle (>=1, fits 23 bits).
REQ-005 Port clk, input, 1, single clock; all logic SHALL be rising-edge clocked on it.
REQ-006 Port rst, input, 1, reset; asynchronous, active-high.
REQ-007 Port cmd_valid, input, 1, command request.
REQ-008 Port cmd_level, input, 1, requested final button level.
REQ-009 Port cmd_ready, output, 1, high exactly when state is IDLE.
REQ-010 Port b, output, 1, emulated mechanical button signal (feeds a debouncer under test).
REQ-011 Port busy, output, 1, high when state is not IDLE.
REQ-012 Port done, output, 1, one-cycle completion pulse.

Function
REQ-013 The block SHALL keep a 16-bit Galois LFSR, polynomial mask 16'hB400, shifted right every clock regardless of state.
REQ-014 States SHALL be IDLE, BOUNCE, SETTLE.
REQ-015 Accept: cmd_valid and cmd_ready both high at edge T; cmd_valid SHALL be ignored in other states.
REQ-016 Accept with cmd_level == b (no-op): at T+1 b unchanged, done = 1, state IDLE, cmd_ready = 1.
REQ-017 Accept with cmd_level != b: at T+1 b = cmd_level; toggles_left = 2 * LFSR[PAIR_W-1:0] sampled at T; gap = 1 + LFSR[GAP_W-1:0] sampled at T (width GAP_W+1, no overflow).
REQ-018 After accept, state SHALL become BOUNCE if toggles_left > 0, else SETTLE with settle counter = SETTLE_CYCLES.
REQ-019 BOUNCE: gap decrements each cycle; on the edge where gap == 1, b inverts, toggles_left decrements, and gap reloads as 1 + LFSR[GAP_W-1:0] sampled at that edge.
REQ-020 BOUNCE: the toggle that brings toggles_left to 0 SHALL move state to SETTLE with settle counter = SETTLE_CYCLES; b then equals cmd_level (even toggle count).
REQ-021 SETTLE: b SHALL hold; counter decrements each cycle; on the edge where it equals 1, state becomes IDLE and done pulses for that one following cycle.
REQ-022 done SHALL never be high for more than one consecutive cycle except for back-to-back no-op commands.
REQ-023 A new command MAY be accepted in the same cycle done is high (cmd_ready is high then).
REQ-024 b SHALL change at most once per clock and only at the edges defined in REQ-016..REQ-020.
REQ-025 Counters SHALL never wrap; the widths of toggles_left (PAIR_W+1), gap (GAP_W+1) and settle (23) SHALL be sized to hold their maxima.

Reset
REQ-026 While rst is high: state IDLE, b = 0, done = 0, busy = 0, cmd_ready = 1, LFSR = SEED (or 1), all counters = 0.
REQ-027 rst asserted mid-BOUNCE or mid-SETTLE SHALL abort the sequence immediately with no done pulse.
REQ-028 First command after rst deassertion SHALL be acceptable on the first rising edge with rst low.

Verification (PAIR_W=2, GAP_W=2, SETTLE_CYCLES=4 unless stated)
REQ-029 Reset then cmd_valid=1, cmd_level=0 for one cycle -> done high at T+1, b stays 0, busy never high.
REQ-030 Reset, cmd_level=1 accepted -> b rises at T+1, exactly 2*LFSR[1:0] further b edges matching a bench LFSR model from seed 16'hACE1, each gap 1..4 cycles, final b=1, done exactly 4 cycles after last toggle.
REQ-031 Force SEED such that LFSR[1:0]=0 at accept -> b rises once, no further toggles, done 4 cycles later.
REQ-032 cmd_valid held high continuously with alternating cmd_level -> each command accepted only when cmd_ready=1, one done per command, b final level alternates, no command lost or duplicated.
REQ-033 rst pulsed for 1 cycle mid-BOUNCE -> b=0, busy=0 asynchronously, no done; next command behaves as after power-up reset.
REQ-034 GAP_W=16, PAIR_W=8, SETTLE_CYCLES=5000000 -> run 20 random commands, assert no counter wrap, done count = command count, b == last cmd_level whenever done=1.
